delay_sweep_ctrl: RTL
=====================

# delay_sweep_ctrl

Training initiator for a DDR delay-line tap register. On `start` it loads the tap register to its reset value and steps it upward one tap at a time with `move`/`direction`, sampling a pass/fail compare result after a settle period at each tap. It records the first and last passing taps, then steps back down to the window centre. It sits between the DDR training sequencer and one delay-tap register instance, driving that register's `direction`/`load`/`move`/`enable` inputs and monitoring its `out_of_range` output.

## Interface

Parameters:
- WIDTH, 7, tap register width; must match the driven tap register.
- RESET_VAL, 1, tap value applied by `load`; must match the tap register; range 1..2^WIDTH-2.
- SETTLE_CYCLES, 4, wait cycles after each step before sampling; range 1..255.
- MIN_WINDOW, 4, minimum passing-window width in taps; used only when DELAY_SWEEP_MIN_WIN_EN is defined.

Ports:
- sclk, in, 1, clock.
- reset_n, in, 1, asynchronous active-low reset.
- start, in, 1, level-sampled training request.
- sample_ok, in, 1, compare result for the current tap; 1 means pass.
- out_of_range, in, 1, from the tap register.
- direction, out, 1, 1 steps up, 0 steps down.
- load, out, 1, one-cycle load pulse.
- move, out, 1, step pulse; the tap register acts on the 0→1 edge.
- enable, out, 1, high while `busy`.
- busy, out, 1, training in progress.
- done, out, 1, training succeeded; sticky until the next accepted `start`.
- fail, out, 1, training failed; sticky until the next accepted `start`.
- tap, out, WIDTH, tracked copy of the tap register value.
- win_start, out, WIDTH, first passing tap.
- win_end, out, WIDTH, last passing tap.

## Operation

States: IDLE, LOAD, SETTLE, SAMPLE, STEP_HI, STEP_LO, CENTER, DONE, FAIL.

- **IDLE**
  - `start`=1 → LOAD.
  - Accepting `start` clears `done`, `fail`, `win_start`, `win_end` and the found flag.
  - `start` is ignored in every state other than IDLE, DONE and FAIL.
- **LOAD**
  - Drives `load`=1 and `enable`=1 for one cycle.
  - Sets `tap`=RESET_VAL.
  - → SETTLE.
- **SETTLE**
  - Counts SETTLE_CYCLES cycles, then → SAMPLE.
- **SAMPLE** (one cycle). Evaluate the rules below in order; the first match wins.
  1. `out_of_range`=1 → FAIL.
  2. `sample_ok`=1 and no pass found yet: `win_start`=`win_end`=`tap`, set the found flag.
  3. `sample_ok`=1 and a pass already found: `win_end`=`tap`.
  4. `sample_ok`=0 and a pass already found → CENTER. The window is closed.
  5. `tap`=2^WIDTH-2, the top limit, with a pass found → CENTER.
  6. `tap`=2^WIDTH-2 with no pass found → FAIL.
  7. Otherwise: `direction`=1 → STEP_HI.
  - All-ones is never requested, so the tap register never self-blocks.
- **STEP_HI**
  - `move`=1 for one cycle; `tap` ± 1 per `direction`.
  - → STEP_LO.
- **STEP_LO**
  - `move`=0 for one cycle, guaranteeing the next 0→1 edge.
  - → SETTLE during the sweep, or → CENTER during centring.
- **CENTER**
  - Target = (`win_start`+`win_end`)>>1, computed with a WIDTH+1-bit sum.
  - `tap`>target: `direction`=0 → STEP_HI.
  - `tap`=target → DONE.
  - If DELAY_SWEEP_MIN_WIN_EN is defined and the width check fails (see Configuration), CENTER goes to FAIL before any step.
- **DONE / FAIL**
  - `busy`=0; `done` or `fail` is held.
  - `start`=1 restarts, same as from IDLE.
- **Output rules**
  - `load` and `move` are never high in the same cycle.
  - `direction` is stable from the STEP_HI cycle through the end of STEP_LO.

## Timing

- Reset values:
  - State IDLE.
  - `direction`=0, `load`=0, `move`=0, `enable`=0.
  - `busy`=0, `done`=0, `fail`=0.
  - `tap`=RESET_VAL, `win_start`=0, `win_end`=0.
- All outputs are registered.
- Latency from `start` sampled high to:
  - `busy`: 1 cycle.
  - `load`: 1 cycle.
- Cost per sweep tap: 2 (step) + SETTLE_CYCLES + 1 (sample) cycles.
- The first sample occurs 1 + SETTLE_CYCLES cycles after LOAD.
- Cost per centring step: 2 cycles, plus 1 CENTER cycle.
- `done`/`fail` assert on the cycle the FSM enters DONE/FAIL; `busy` deasserts on the same cycle.
- Reset mid-operation:
  - Immediate return to reset values.
  - The tap register shares `reset_n`, so `tap` stays consistent with it.

## Configuration

- DELAY_SWEEP_MIN_WIN_EN defined:
  - In CENTER, if `win_end`-`win_start`+1 < MIN_WINDOW → FAIL, with no centring steps.
- DELAY_SWEEP_MIN_WIN_EN undefined:
  - MIN_WINDOW is unused.
  - Any window of 1 or more taps proceeds to centring.

## Test plan

All scenarios use WIDTH=7, RESET_VAL=1, SETTLE_CYCLES=4, with the controller connected to a behavioural tap register model.

1. **Normal window.** `sample_ok`=1 for taps 20..40 → `win_start`=20, `win_end`=40, final `tap`=30, `done`=1. Expect 40 up-steps (1→41) and 11 down-steps.
2. **No pass.** `sample_ok` always 0 → sweep reaches `tap`=126, `fail`=1, `win_start`=0, and no `move` edge with `direction`=0.
3. **Full-range pass.** `sample_ok` always 1 → `win_start`=1, `win_end`=126, final `tap`=63, `done`=1. The tap register model never reaches 127.
4. **Minimum window.** Macro defined with MIN_WINDOW=4, pass at taps 50..51 → `fail`=1 and `tap`=52. Macro undefined with the same stimulus → `done`=1 and `tap`=50.
5. **Fault injection.** Force `out_of_range`=1 during the sample at tap 10 → `fail`=1 on the next cycle.
6. **Restart and reset.**
   - `start` pulsed while `busy` → ignored, and the trace matches scenario 1.
   - `reset_n` low at `tap`=60 → `busy`=0 and `tap`=1 immediately.
   - A new `start` then completes scenario 1.

Source files
------------

// File: rtl/delay_sweep_ctrl.sv
// delay_sweep_ctrl: DDR delay-line training initiator.
// Loads the tap register, sweeps it upward one tap at a time, samples a
// pass/fail compare after a settle period, records the passing window and
// then steps back down to the window centre.
// Optional feature macro: DELAY_SWEEP_MIN_WIN_EN (reject windows narrower
// than MIN_WINDOW taps before centring).
module delay_sweep_ctrl #(
    parameter int unsigned WIDTH         = 7,
    parameter int unsigned RESET_VAL     = 1,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned MIN_WINDOW    = 4
) (
    input  logic             sclk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             sample_ok,
    input  logic             out_of_range,
    output logic             direction,
    output logic             load,
    output logic             move,
    output logic             enable,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] win_start,
    output logic [WIDTH-1:0] win_end
);

    localparam logic [3:0] StIdle   = 4'd0;
    localparam logic [3:0] StLoad   = 4'd1;
    localparam logic [3:0] StSettle = 4'd2;
    localparam logic [3:0] StSample = 4'd3;
    localparam logic [3:0] StStepHi = 4'd4;
    localparam logic [3:0] StStepLo = 4'd5;
    localparam logic [3:0] StCenter = 4'd6;
    localparam logic [3:0] StDone   = 4'd7;
    localparam logic [3:0] StFail   = 4'd8;

    // Highest tap ever requested; all-ones is avoided so the register never self-blocks.
    localparam logic [WIDTH-1:0] TapTop   = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] TapReset = WIDTH'(RESET_VAL);
    localparam logic [WIDTH-1:0] TapOne   = WIDTH'(1);
    localparam logic [7:0]       SettleLast = 8'(SETTLE_CYCLES - 1);

    logic [3:0]       state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             found_q, found_d;
    logic             centering_q, centering_d;
    logic             dir_d;
    logic [WIDTH-1:0] tap_d, win_start_d, win_end_d;
    logic [WIDTH:0]   win_sum;
    logic [WIDTH-1:0] target;
    logic             busy_d;
    logic             win_too_narrow;

    // Centre of the window, summed one bit wider so it cannot wrap.
    assign win_sum = {1'b0, win_start} + {1'b0, win_end};
    assign target  = win_sum[WIDTH:1];

`ifdef DELAY_SWEEP_MIN_WIN_EN
    logic [WIDTH:0] win_len;
    assign win_len        = {1'b0, win_end} - {1'b0, win_start} + {{WIDTH{1'b0}}, 1'b1};
    assign win_too_narrow = (32'(win_len) < MIN_WINDOW);
`else
    logic unused_min_window;
    assign unused_min_window = (MIN_WINDOW != 0);
    assign win_too_narrow    = 1'b0;
`endif

    // Next-state and datapath update for the sweep/centre sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        found_d     = found_q;
        centering_d = centering_q;
        dir_d       = direction;
        tap_d       = tap;
        win_start_d = win_start;
        win_end_d   = win_end;
        case (state_q)
            StIdle, StDone, StFail: begin
                if (start) begin
                    state_d     = StLoad;
                    win_start_d = '0;
                    win_end_d   = '0;
                    found_d     = 1'b0;
                    centering_d = 1'b0;
                end
            end
            StLoad: begin
                tap_d   = TapReset;
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == SettleLast) begin
                    cnt_d   = '0;
                    state_d = StSample;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            StSample: begin
                if (out_of_range) begin
                    state_d = StFail;
                end else begin
                    if (sample_ok) begin
                        if (!found_q) begin
                            win_start_d = tap;
                        end
                        win_end_d = tap;
                        found_d   = 1'b1;
                    end
                    if (!sample_ok && found_q) begin
                        // Window has closed.
                        state_d     = StCenter;
                        centering_d = 1'b1;
                    end else if (tap == TapTop) begin
                        state_d     = found_d ? StCenter : StFail;
                        centering_d = found_d;
                    end else begin
                        dir_d   = 1'b1;
                        state_d = StStepHi;
                    end
                end
            end
            StStepHi: begin
                tap_d   = direction ? tap + TapOne : tap - TapOne;
                state_d = StStepLo;
            end
            StStepLo: begin
                cnt_d   = '0;
                state_d = centering_q ? StCenter : StSettle;
            end
            StCenter: begin
                if (win_too_narrow) begin
                    state_d = StFail;
                end else if (tap > target) begin
                    dir_d   = 1'b0;
                    state_d = StStepHi;
                end else if (tap < target) begin
                    dir_d   = 1'b1;
                    state_d = StStepHi;
                end else begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy_d = !((state_d == StIdle) || (state_d == StDone) || (state_d == StFail));

    // State, datapath and registered outputs derived from the next state.
    always_ff @(posedge sclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            found_q     <= 1'b0;
            centering_q <= 1'b0;
            direction   <= 1'b0;
            load        <= 1'b0;
            move        <= 1'b0;
            enable      <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            tap         <= TapReset;
            win_start   <= '0;
            win_end     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            found_q     <= found_d;
            centering_q <= centering_d;
            direction   <= dir_d;
            load        <= (state_d == StLoad);
            move        <= (state_d == StStepHi);
            enable      <= busy_d;
            busy        <= busy_d;
            done        <= (state_d == StDone);
            fail        <= (state_d == StFail);
            tap         <= tap_d;
            win_start   <= win_start_d;
            win_end     <= win_end_d;
        end
    end

endmodule
